// File: rtl/serial_pattern_tx.sv
// Serial bit-stream transmitter: load/ready word intake, one bit per clock on x.
// Optional even-parity trailer bit with SERIAL_PATTERN_TX_PARITY_EN defined.
module serial_pattern_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             x,
  output logic             x_valid,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SERIAL_PATTERN_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
  logic par_bit;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh;

  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] data_sh;
  logic [WIDTH-1:0] sh_sh;

  // ready is registered and only high in IDLE or the final bit cycle
  assign accept    = load & ready;
  assign first_bit = MSB_FIRST ? data[WIDTH-1] : data[0];
  assign next_bit  = MSB_FIRST ? sh[WIDTH-1] : sh[0];
  assign data_sh   = MSB_FIRST ? {data[WIDTH-2:0], 1'b0} : {1'b0, data[WIDTH-1:1]};
  assign sh_sh     = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sh      <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      done    <= 1'b0;
      ready   <= 1'b1;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else if (accept) begin
      // first bit goes straight to x; sh holds the remaining bits
      state   <= SHIFT;
      cnt     <= '0;
      sh      <= data_sh;
      x       <= first_bit;
      x_valid <= 1'b1;
      done    <= 1'b0;
      ready   <= 1'b0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      par_bit <= ^data;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (cnt == LAST) begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            state   <= PAR;
            x       <= par_bit;
            x_valid <= 1'b1;
            done    <= 1'b1;
            ready   <= 1'b1;
`else
            state   <= IDLE;
            x       <= 1'b0;
            x_valid <= 1'b0;
            done    <= 1'b0;
            ready   <= 1'b1;
`endif
          end else begin
            cnt     <= cnt + 1'b1;
            sh      <= sh_sh;
            x       <= next_bit;
            x_valid <= 1'b1;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            done    <= 1'b0;
            ready   <= 1'b0;
`else
            done    <= (cnt == LAST - 1'b1);
            ready   <= (cnt == LAST - 1'b1);
`endif
          end
        end
        default: begin
          state   <= IDLE;
          x       <= 1'b0;
          x_valid <= 1'b0;
          done    <= 1'b0;
          ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx: MSB-first and LSB-first instances share stimulus.
// Expected bits include the parity trailer when SERIAL_PATTERN_TX_PARITY_EN is defined.
module tb_serial_pattern_tx;

`ifdef SERIAL_PATTERN_TX_PARITY_EN
  localparam int  WL  = 9;
  localparam bit  PAR = 1'b1;
`else
  localparam int  WL  = 8;
  localparam bit  PAR = 1'b0;
`endif

  typedef struct packed {
    logic x;
    logic done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [7:0] data = 8'h00;

  logic ready_m, x_m, x_valid_m, done_m;
  logic ready_l, x_l, x_valid_l, done_l;

  exp_t q_m[$];
  exp_t q_l[$];
  int n_pass = 0;
  int n_total = 0;
  int run_m = 0;
  int last_run_m = 0;

  always #5 clk = ~clk;

  serial_pattern_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .load(load), .data(data),
    .ready(ready_m), .x(x_m), .x_valid(x_valid_m), .done(done_m));

  serial_pattern_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .load(load), .data(data),
    .ready(ready_l), .x(x_l), .x_valid(x_valid_l), .done(done_l));

  function automatic void check(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endfunction

  function automatic void push_word(logic [7:0] d);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.done = (i == 7) && !PAR;
      e.x = d[7-i];
      q_m.push_back(e);
      e.x = d[i];
      q_l.push_back(e);
    end
    if (PAR) begin
      e.x = ^d;
      e.done = 1'b1;
      q_m.push_back(e);
      q_l.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (x_valid_m) begin
        if (q_m.size() == 0) begin
          n_total++;
          $display("FAIL msb_unexpected_bit: got x=%0d expected no valid bit", x_m);
        end else begin
          e = q_m.pop_front();
          check("msb_x", x_m, e.x);
          check("msb_done", done_m, e.done);
        end
        run_m++;
      end else begin
        check("msb_idle_x_done", {done_m, x_m}, 0);
        if (run_m != 0) begin
          last_run_m = run_m;
          run_m = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (x_valid_l) begin
        if (q_l.size() == 0) begin
          n_total++;
          $display("FAIL lsb_unexpected_bit: got x=%0d expected no valid bit", x_l);
        end else begin
          e = q_l.pop_front();
          check("lsb_x", x_l, e.x);
          check("lsb_done", done_l, e.done);
        end
      end else begin
        check("lsb_idle_x_done", {done_l, x_l}, 0);
      end
    end
  end

  // Returns at the negedge of the cycle carrying the word's first bit.
  task automatic send(input logic [7:0] d);
    int guard = 0;
    @(negedge clk);
    while (!ready_m && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("send_ready_timeout", 0, 1);
    load = 1'b1;
    data = d;
    push_word(d);
    @(negedge clk);
    load = 1'b0;
    data = 8'h3C;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((q_m.size() != 0 || q_l.size() != 0 || x_valid_m) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("idle_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int guard;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", ready_m, 1);
    check("rst_x_valid", x_valid_m, 0);
    check("rst_x_done", {x_m, done_m}, 0);
    rst = 1'b0;

    // basic word in both bit orders
    send(8'b1011_0010);
    wait_idle();
    check("idle_ready", ready_m, 1);

    // back-to-back: FF then 00 with load held on the done cycle
    send(8'hFF);
    send(8'h00);
    wait_idle();
    check("b2b_run_len", last_run_m, 2 * WL);

    // load during bit 3 of A5 is dropped
    send(8'hA5);
    repeat (3) @(negedge clk);
    check("busy_ready", ready_m, 0);
    load = 1'b1;
    data = 8'h55;
    @(negedge clk);
    load = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("busy_no_extra", x_valid_m, 0);

    // reset after three bits of F0
    send(8'hF0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    load = 1'b1;
    data = 8'h99;
    @(posedge clk);
    #1;
    rst = 1'b0;
    load = 1'b0;
    q_m.delete();
    q_l.delete();
    @(negedge clk);
    check("midrst_ready", ready_m, 1);
    check("midrst_x_valid", x_valid_m, 0);
    check("midrst_x_done", {x_m, done_m}, 0);
    send(8'h81);
    wait_idle();

    // parity-oriented words, then gap timing of 3 cycles after done
    send(8'b0000_0111);
    guard = 0;
    while (!done_m && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("gap_done_seen", done_m, 1);
    repeat (3) begin
      @(negedge clk);
      check("gap_x_valid_low", x_valid_m, 0);
    end
    load = 1'b1;
    data = 8'b1011_0010;
    push_word(8'b1011_0010);
    @(negedge clk);
    load = 1'b0;
    check("gap_first_bit_valid", x_valid_m, 1);
    wait_idle();

    check("queues_drained", q_m.size() + q_l.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
